// File: rtl/ravenoc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ravenoc_pkg
// Description : Flit format and arbiter state definitions. This package is
//               shared by the router output arbiter and the input router.
// Revision    : 1.0 - initial release
// ============================================================================
package ravenoc_pkg;

  localparam int FLIT_W        = 34;
  localparam int N_PORTS       = 5;
  localparam int FLIT_TYPE_MSB = 33;
  localparam int FLIT_TYPE_LSB = 32;

  localparam logic [1:0] FLIT_HEAD      = 2'b00;
  localparam logic [1:0] FLIT_BODY      = 2'b01;
  localparam logic [1:0] FLIT_TAIL      = 2'b10;
  localparam logic [1:0] FLIT_HEAD_TAIL = 2'b11;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // A flit of either of these types starts a packet.
  function automatic logic is_head(input logic [1:0] ftype);
    return (ftype == FLIT_HEAD) || (ftype == FLIT_HEAD_TAIL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. It scans the requests
//               starting just after ptr_i and returns the first requester
//               as a one-hot vector plus its index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 5,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] gnt_idx_o,
  output logic             any_o
);

  // Walk ptr+1, ptr+2, ... modulo N and stop at the first request.
  always_comb begin
    logic found;
    int   idx;
    found     = 1'b0;
    idx       = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = PTR_W'(idx);
      end
    end
    any_o = found;
  end

endmodule
`default_nettype wire

// File: rtl/output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : output_arbiter
// Description : Wormhole arbiter for one router output port. It grants one
//               packet at a time in round-robin order, holds the grant from
//               head to tail, and drives a single registered flit stage.
// Revision    : 1.0 - initial release
// ============================================================================
module output_arbiter
  import ravenoc_pkg::*;
#(
  parameter int N_INPUTS = 5,
  parameter int FLIT_W   = 34
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic [N_INPUTS-1:0]          req_i,
  input  logic [N_INPUTS*FLIT_W-1:0]   flit_i,
  output logic [N_INPUTS-1:0]          ready_o,
  output logic                         out_valid_o,
  output logic [FLIT_W-1:0]            out_flit_o,
  input  logic                         out_ready_i,
  output logic [N_INPUTS-1:0]          owner_o,
  output logic                         err_o
);

  localparam int PTR_W    = $clog2(N_INPUTS);
  localparam int TYPE_LSB = FLIT_W - 2;

  arb_state_t            state_q;
  logic [PTR_W-1:0]      rr_ptr_q;
  logic [N_INPUTS-1:0]   owner_q;
  logic [PTR_W-1:0]      owner_idx_q;
  logic                  out_valid_q;
  logic [FLIT_W-1:0]     out_flit_q;
  logic                  err_q;

  logic [1:0]            ftype   [N_INPUTS];
  logic [FLIT_W-1:0]     flit_arr[N_INPUTS];
  logic [N_INPUTS-1:0]   cand;
  logic [N_INPUTS-1:0]   stray;

  logic [N_INPUTS-1:0]   gnt;
  logic [PTR_W-1:0]      gnt_idx;
  logic                  gnt_any;

  logic                  slot_free;
  logic [N_INPUTS-1:0]   ready_d;
  logic                  accept_d;
  logic                  err_d;
  logic [PTR_W-1:0]      sel_idx;
  logic [FLIT_W-1:0]     sel_flit;
  logic [1:0]            sel_type;

  // Split the packed bus and classify each request as packet start or not.
  for (genvar i = 0; i < N_INPUTS; i++) begin : g_unpack
    assign flit_arr[i] = flit_i[i*FLIT_W +: FLIT_W];
    assign ftype[i]    = flit_i[i*FLIT_W + TYPE_LSB +: 2];
    assign cand[i]     = req_i[i] &  is_head(ftype[i]);
    assign stray[i]    = req_i[i] & ~is_head(ftype[i]);
  end

  rr_arbiter #(
    .N     (N_INPUTS),
    .PTR_W (PTR_W)
  ) u_rr (
    .req_i     (cand),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  // The stage can take a flit if it is empty or being drained this cycle.
  assign slot_free = ~out_valid_q | out_ready_i;

  // Decide who transfers this cycle and whether a protocol violation is seen.
  always_comb begin
    ready_d  = '0;
    accept_d = 1'b0;
    err_d    = 1'b0;
    sel_idx  = gnt_idx;
    if (state_q == ARB_IDLE) begin
      // Body/tail flits with no open packet are never granted.
      err_d = |stray;
      if (slot_free && gnt_any) begin
        ready_d  = gnt;
        accept_d = 1'b1;
      end
    end else begin
      sel_idx = owner_idx_q;
      if (req_i[owner_idx_q]) begin
        if (is_head(ftype[owner_idx_q])) begin
          // The owner tried to open a second packet; refuse it and keep the lock.
          err_d = 1'b1;
        end else if (slot_free) begin
          ready_d[owner_idx_q] = 1'b1;
          accept_d             = 1'b1;
        end
      end
    end
  end

  assign sel_flit = flit_arr[sel_idx];
  assign sel_type = ftype[sel_idx];

  // FSM, grant bookkeeping, output stage and error pulse.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= PTR_W'(N_INPUTS - 1);
      owner_q     <= '0;
      owner_idx_q <= '0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= err_d;

      if (accept_d) begin
        out_valid_q <= 1'b1;
        out_flit_q  <= sel_flit;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end

      if (state_q == ARB_IDLE) begin
        if (accept_d) begin
          rr_ptr_q <= gnt_idx;
          if (sel_type == FLIT_HEAD) begin
            state_q     <= ARB_LOCKED;
            owner_q     <= gnt;
            owner_idx_q <= gnt_idx;
          end
        end
      end else begin
        if (accept_d && (sel_type == FLIT_TAIL)) begin
          state_q <= ARB_IDLE;
          owner_q <= '0;
        end
      end
    end
  end

  // Ready is combinational, so it is forced low while reset is asserted.
  assign ready_o     = arst ? '0 : ready_d;
  assign out_valid_o = out_valid_q;
  assign out_flit_o  = out_flit_q;
  assign owner_o     = owner_q;
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_arbiter
// Description : Directed self-checking bench for output_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_arbiter;
  import ravenoc_pkg::*;

  localparam int N = 5;
  localparam int W = 34;

  logic             clk = 1'b0;
  logic             arst;
  logic [N-1:0]     req_i;
  logic [N*W-1:0]   flit_i;
  logic [N-1:0]     ready_o;
  logic             out_valid_o;
  logic [W-1:0]     out_flit_o;
  logic             out_ready_i;
  logic [N-1:0]     owner_o;
  logic             err_o;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q[N][8];
  int           qlen[N];
  int           qptr[N];
  logic [N-1:0] last_rdy;

  output_arbiter #(.N_INPUTS(N), .FLIT_W(W)) dut (
    .clk         (clk),
    .arst        (arst),
    .req_i       (req_i),
    .flit_i      (flit_i),
    .ready_o     (ready_o),
    .out_valid_o (out_valid_o),
    .out_flit_o  (out_flit_o),
    .out_ready_i (out_ready_i),
    .owner_o     (owner_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic [1:0] t, input int src, input int seq);
    logic [7:0]  s8;
    logic [23:0] q24;
    s8  = src[7:0];
    q24 = seq[23:0];
    return {t, s8, q24};
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (qptr[i] < qlen[i]) begin
        req_i[i]         = 1'b1;
        flit_i[i*W +: W] = q[i][qptr[i]];
      end else begin
        req_i[i]         = 1'b0;
        flit_i[i*W +: W] = '0;
      end
    end
  endtask

  // Sample ready at the falling edge, let one rising edge pass, then advance
  // every source whose flit was consumed.
  task automatic tick();
    logic [N-1:0] rq;
    @(negedge clk);
    last_rdy = ready_o;
    rq       = req_i;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rq[i] && last_rdy[i]) qptr[i]++;
    end
    drive();
  endtask

  task automatic clear_q();
    for (int i = 0; i < N; i++) begin
      qlen[i] = 0;
      qptr[i] = 0;
    end
    drive();
  endtask

  task automatic push(input int i, input logic [1:0] t, input int seq);
    q[i][qlen[i]] = mk(t, i, seq);
    qlen[i]++;
  endtask

  task automatic do_reset();
    clear_q();
    out_ready_i = 1'b1;
    arst = 1'b1;
    tick();
    tick();
    arst = 1'b0;
  endtask

  task automatic test_reset();
    clear_q();
    for (int i = 0; i < N; i++) push(i, FLIT_HEAD, 0);
    drive();
    out_ready_i = 1'b1;
    arst = 1'b1;
    tick();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid_o); end
    checks++; if (last_rdy !== 5'b00000) begin errors++; $display("FAIL reset_ready: got %b want 00000", last_rdy); end
    checks++; if (owner_o !== 5'b00000) begin errors++; $display("FAIL reset_owner: got %b want 00000", owner_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_o); end
    tick();
    checks++; if (last_rdy !== 5'b00000) begin errors++; $display("FAIL reset_ready2: got %b want 00000", last_rdy); end
    arst = 1'b0;
    tick();
    checks++; if (last_rdy !== 5'b00001) begin errors++; $display("FAIL reset_first_ready: got %b want 00001", last_rdy); end
    checks++; if (out_flit_o !== mk(FLIT_HEAD, 0, 0) || out_valid_o !== 1'b1) begin
      errors++; $display("FAIL reset_first_flit: got %h v=%b want %h v=1", out_flit_o, out_valid_o, mk(FLIT_HEAD, 0, 0)); end
    checks++; if (owner_o !== 5'b00001) begin errors++; $display("FAIL reset_first_owner: got %b want 00001", owner_o); end
  endtask

  task automatic test_contention();
    logic [1:0]   tys[3];
    int           src;
    logic [W-1:0] exp;
    tys = '{FLIT_HEAD, FLIT_BODY, FLIT_TAIL};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push(1, tys[k], k);
      push(3, tys[k], k);
    end
    drive();
    for (int k = 0; k < 6; k++) begin
      tick();
      src = (k < 3) ? 1 : 3;
      exp = mk(tys[k % 3], src, k % 3);
      checks++; if (out_valid_o !== 1'b1 || out_flit_o !== exp) begin
        errors++; $display("FAIL cont_flit%0d: got %h v=%b want %h v=1", k, out_flit_o, out_valid_o, exp); end
      if (k == 0) begin
        checks++; if (owner_o !== 5'b00010) begin errors++; $display("FAIL cont_owner1: got %b want 00010", owner_o); end
      end
      if (k == 3) begin
        checks++; if (owner_o !== 5'b01000) begin errors++; $display("FAIL cont_owner3: got %b want 01000", owner_o); end
      end
    end
    checks++; if (owner_o !== 5'b00000) begin errors++; $display("FAIL cont_owner_end: got %b want 00000", owner_o); end
    tick();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL cont_drain: got %b want 0", out_valid_o); end
  endtask

  task automatic test_rr();
    logic [W-1:0] exp;
    do_reset();
    for (int i = 0; i < N; i++) begin
      push(i, FLIT_HEAD_TAIL, 0);
      push(i, FLIT_HEAD_TAIL, 1);
    end
    drive();
    for (int k = 0; k < 10; k++) begin
      tick();
      exp = mk(FLIT_HEAD_TAIL, k % 5, k / 5);
      checks++; if (out_valid_o !== 1'b1 || out_flit_o !== exp) begin
        errors++; $display("FAIL rr_flit%0d: got %h v=%b want %h v=1", k, out_flit_o, out_valid_o, exp); end
      checks++; if (owner_o !== 5'b00000) begin errors++; $display("FAIL rr_owner%0d: got %b want 00000", k, owner_o); end
    end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rr_err: got %b want 0", err_o); end
  endtask

  task automatic test_backpressure();
    do_reset();
    push(0, FLIT_HEAD, 0);
    push(0, FLIT_BODY, 1);
    push(0, FLIT_BODY, 2);
    push(0, FLIT_TAIL, 3);
    drive();
    tick();
    tick();
    checks++; if (out_flit_o !== mk(FLIT_BODY, 0, 1)) begin errors++; $display("FAIL bp_pre: got %h want %h", out_flit_o, mk(FLIT_BODY, 0, 1)); end
    out_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (last_rdy !== 5'b00000) begin errors++; $display("FAIL bp_ready%0d: got %b want 00000", k, last_rdy); end
      checks++; if (out_valid_o !== 1'b1 || out_flit_o !== mk(FLIT_BODY, 0, 1)) begin
        errors++; $display("FAIL bp_hold%0d: got %h v=%b want %h v=1", k, out_flit_o, out_valid_o, mk(FLIT_BODY, 0, 1)); end
    end
    out_ready_i = 1'b1;
    tick();
    checks++; if (last_rdy !== 5'b00001) begin errors++; $display("FAIL bp_release_ready: got %b want 00001", last_rdy); end
    checks++; if (out_flit_o !== mk(FLIT_BODY, 0, 2)) begin errors++; $display("FAIL bp_body2: got %h want %h", out_flit_o, mk(FLIT_BODY, 0, 2)); end
    tick();
    checks++; if (out_flit_o !== mk(FLIT_TAIL, 0, 3)) begin errors++; $display("FAIL bp_tail: got %h want %h", out_flit_o, mk(FLIT_TAIL, 0, 3)); end
    checks++; if (owner_o !== 5'b00000) begin errors++; $display("FAIL bp_owner: got %b want 00000", owner_o); end
    tick();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out_valid_o); end
  endtask

  task automatic test_errors();
    do_reset();
    push(2, FLIT_BODY, 0);
    drive();
    tick();
    checks++; if (last_rdy !== 5'b00000) begin errors++; $display("FAIL err_idle_ready: got %b want 00000", last_rdy); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_idle_body: got %b want 1", err_o); end
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL err_idle_valid: got %b want 0", out_valid_o); end
    qptr[2] = qlen[2];
    drive();
    tick();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_pulse_end: got %b want 0", err_o); end
    clear_q();
    push(2, FLIT_HEAD, 0);
    push(2, FLIT_HEAD, 1);
    push(2, FLIT_TAIL, 2);
    drive();
    tick();
    checks++; if (owner_o !== 5'b00100) begin errors++; $display("FAIL err_lock_owner: got %b want 00100", owner_o); end
    tick();
    checks++; if (last_rdy !== 5'b00000) begin errors++; $display("FAIL err_head_ready: got %b want 00000", last_rdy); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_locked_head: got %b want 1", err_o); end
    checks++; if (owner_o !== 5'b00100) begin errors++; $display("FAIL err_lock_kept: got %b want 00100", owner_o); end
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL err_head_dropped: got %b want 0", out_valid_o); end
    qptr[2]++;
    drive();
    tick();
    checks++; if (out_flit_o !== mk(FLIT_TAIL, 2, 2) || out_valid_o !== 1'b1) begin
      errors++; $display("FAIL err_tail: got %h v=%b want %h v=1", out_flit_o, out_valid_o, mk(FLIT_TAIL, 2, 2)); end
    checks++; if (err_o !== 1'b0 || owner_o !== 5'b00000) begin
      errors++; $display("FAIL err_after_tail: got err=%b owner=%b want err=0 owner=00000", err_o, owner_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(4, FLIT_HEAD, 0);
    push(4, FLIT_BODY, 1);
    push(4, FLIT_BODY, 2);
    push(4, FLIT_TAIL, 3);
    drive();
    tick();
    tick();
    checks++; if (owner_o !== 5'b10000 || out_flit_o !== mk(FLIT_BODY, 4, 1)) begin
      errors++; $display("FAIL mid_pre: got owner=%b flit=%h want owner=10000 flit=%h", owner_o, out_flit_o, mk(FLIT_BODY, 4, 1)); end
    arst = 1'b1;
    tick();
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", out_valid_o); end
    checks++; if (owner_o !== 5'b00000) begin errors++; $display("FAIL mid_owner: got %b want 00000", owner_o); end
    arst = 1'b0;
    clear_q();
    push(2, FLIT_HEAD, 0);
    push(2, FLIT_TAIL, 1);
    drive();
    tick();
    checks++; if (out_flit_o !== mk(FLIT_HEAD, 2, 0) || out_valid_o !== 1'b1) begin
      errors++; $display("FAIL mid_new_head: got %h v=%b want %h v=1", out_flit_o, out_valid_o, mk(FLIT_HEAD, 2, 0)); end
    checks++; if (owner_o !== 5'b00100) begin errors++; $display("FAIL mid_new_owner: got %b want 00100", owner_o); end
    tick();
    checks++; if (out_flit_o !== mk(FLIT_TAIL, 2, 1) || owner_o !== 5'b00000) begin
      errors++; $display("FAIL mid_new_tail: got %h owner=%b want %h owner=00000", out_flit_o, owner_o, mk(FLIT_TAIL, 2, 1)); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    arst        = 1'b1;
    out_ready_i = 1'b1;
    req_i       = '0;
    flit_i      = '0;
    last_rdy    = '0;
    clear_q();
    test_reset();
    test_contention();
    test_rr();
    test_backpressure();
    test_errors();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
